gnn_node_scheduler: RTL and testbench

GNN_NODE_SCHEDULER -- requirements
Module: gnn_node_scheduler

---
 rtl/gnn_node_scheduler.sv | 218 +++++++++++++++++++++
 tb/tb_gnn_node_scheduler.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gnn_node_scheduler.sv
// gnn_node_scheduler: walks the enabled nodes of a 4-node graph in ascending order, issuing aggregate,
// shared-engine launch and combine pulses per node. Define GNN_SCHED_TIMEOUT_EN for the engine watchdog.
module gnn_node_scheduler (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic [15:0] adj,
   input  logic [3:0]  node_en,
   input  logic        eng_done,
   output logic [1:0]  cur_node,
   output logic        agg_load,
   output logic [3:0]  agg_mask,
   output logic        eng_start,
   output logic        comb_load,
   output logic        busy,
   output logic        done,
   output logic [2:0]  node_cnt,
   output logic        err
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_AGG  = 3'd1,
      S_EXEC = 3'd2,
      S_WAIT = 3'd3,
      S_COMB = 3'd4,
      S_DONE = 3'd5
`ifdef GNN_SCHED_TIMEOUT_EN
      , S_TOUT = 3'd6
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] adj_q, adj_d;
   logic [3:0]  en_q, en_d;
   logic [1:0]  cur_node_q, cur_node_d;
   logic [2:0]  node_cnt_q, node_cnt_d;
   logic [3:0]  agg_mask_q, agg_mask_d;
   logic        agg_load_q, agg_load_d;
   logic        eng_start_q, eng_start_d;
   logic        comb_load_q, comb_load_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic [2:0]  first_sel_s;
   logic [2:0]  next_sel_s;

   // Lowest enabled node index >= from; bit 2 set means no such node.
   function automatic logic [2:0] find_node(input logic [3:0] en, input logic [2:0] from);
      logic [2:0] res;
      res = 3'b100;
      for (int i = 3; i >= 0; i--) begin
         res = (en[i] && (3'(i) >= from)) ? 3'(i) : res;
      end
      return res;
   endfunction

   function automatic logic [3:0] adj_row(input logic [15:0] a, input logic [1:0] n);
      logic [3:0] row;
      case (n)
         2'd0:    row = a[3:0];
         2'd1:    row = a[7:4];
         2'd2:    row = a[11:8];
         2'd3:    row = a[15:12];
         default: row = 4'h0;
      endcase
      return row;
   endfunction

   assign first_sel_s = find_node(node_en, 3'd0);
   assign next_sel_s  = find_node(en_q, {1'b0, cur_node_q} + 3'd1);

`ifdef GNN_SCHED_TIMEOUT_EN
   logic [7:0] tout_cnt_q, tout_cnt_d;
   logic       err_q, err_d;

   // Watchdog counts cycles spent in WAIT; restarts from zero on every entry.
   always_comb begin
      tout_cnt_d = 8'd0;
      err_d      = err_q;
      if (state_q == S_WAIT) begin
         tout_cnt_d = tout_cnt_q + 8'd1;
      end else begin
         tout_cnt_d = 8'd0;
      end
      if (state_q == S_IDLE && start) begin
         err_d = 1'b0;
      end else if (state_d == S_TOUT) begin
         err_d = 1'b1;
      end else begin
         err_d = err_q;
      end
   end

   // Watchdog state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tout_cnt_q <= 8'd0;
         err_q      <= 1'b0;
      end else begin
         tout_cnt_q <= tout_cnt_d;
         err_q      <= err_d;
      end
   end

   assign err = err_q;
`else
   assign err = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = first_sel_s[2] ? S_DONE : S_AGG;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_AGG:  state_d = S_EXEC;
         S_EXEC: state_d = S_WAIT;
         S_WAIT: begin
            if (eng_done) begin
               state_d = S_COMB;
`ifdef GNN_SCHED_TIMEOUT_EN
            end else if (tout_cnt_q == 8'hFF) begin
               state_d = S_TOUT;
`endif
            end else begin
               state_d = S_WAIT;
            end
         end
         S_COMB: state_d = next_sel_s[2] ? S_DONE : S_AGG;
         S_DONE: state_d = S_IDLE;
`ifdef GNN_SCHED_TIMEOUT_EN
         S_TOUT: state_d = S_DONE;
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Pass context: graph snapshot, node pointer and completion count.
   always_comb begin
      adj_d      = adj_q;
      en_d       = en_q;
      cur_node_d = cur_node_q;
      node_cnt_d = node_cnt_q;
      if (state_q == S_IDLE && start) begin
         adj_d      = adj;
         en_d       = node_en;
         node_cnt_d = 3'd0;
         cur_node_d = first_sel_s[2] ? 2'd0 : first_sel_s[1:0];
      end else if (state_d == S_COMB) begin
         node_cnt_d = node_cnt_q + 3'd1;
      end else if (state_q == S_COMB && !next_sel_s[2]) begin
         cur_node_d = next_sel_s[1:0];
      end else begin
         cur_node_d = cur_node_q;
      end
   end

   // Outputs decoded from the upcoming state so each pulse is a flop aligned with its state.
   always_comb begin
      agg_load_d  = (state_d == S_AGG);
      eng_start_d = (state_d == S_EXEC);
      comb_load_d = (state_d == S_COMB);
      done_d      = (state_d == S_DONE);
      busy_d      = (state_d != S_IDLE);
      agg_mask_d  = adj_row(adj_d, cur_node_d);
   end

   // Context and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adj_q       <= 16'h0000;
         en_q        <= 4'h0;
         cur_node_q  <= 2'd0;
         node_cnt_q  <= 3'd0;
         agg_mask_q  <= 4'h0;
         agg_load_q  <= 1'b0;
         eng_start_q <= 1'b0;
         comb_load_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         adj_q       <= adj_d;
         en_q        <= en_d;
         cur_node_q  <= cur_node_d;
         node_cnt_q  <= node_cnt_d;
         agg_mask_q  <= agg_mask_d;
         agg_load_q  <= agg_load_d;
         eng_start_q <= eng_start_d;
         comb_load_q <= comb_load_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cur_node  = cur_node_q;
   assign node_cnt  = node_cnt_q;
   assign agg_mask  = agg_mask_q;
   assign agg_load  = agg_load_q;
   assign eng_start = eng_start_q;
   assign comb_load = comb_load_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_gnn_node_scheduler.sv
// Directed self-checking bench for gnn_node_scheduler; cycle 0 is the cycle in which start is driven.
module tb_gnn_node_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] adj = 16'h0000;
   logic [3:0]  node_en = 4'h0;
   logic        eng_done = 1'b0;
   logic [1:0]  cur_node;
   logic        agg_load, eng_start, comb_load, busy, done, err;
   logic [3:0]  agg_mask;
   logic [2:0]  node_cnt;

   int errors = 0;
   int checks = 0;

   int         es_cyc[$];
   logic [3:0] mask_log[$];
   logic [1:0] node_log[$];
   int         done_cyc, n_agg, n_comb, busy_cycles, stab_err;
   logic [2:0] done_cnt;
   logic       err_at_done;

   gnn_node_scheduler dut (
      .clk(clk), .rst_n(rst_n), .start(start), .adj(adj), .node_en(node_en),
      .eng_done(eng_done), .cur_node(cur_node), .agg_load(agg_load), .agg_mask(agg_mask),
      .eng_start(eng_start), .comb_load(comb_load), .busy(busy), .done(done),
      .node_cnt(node_cnt), .err(err)
   );

   always #5 clk = ~clk;

   // One pass with an engine model of latency lat (0 = engine never answers).
   task automatic run_pass(input logic [15:0] a, input logic [3:0] en, input int lat,
                           input int max_cyc, input int restart_cyc, input int spur_cyc);
      int pend;
      logic [1:0] last_node;
      logic [3:0] last_mask;
      pend = -1;
      es_cyc.delete(); mask_log.delete(); node_log.delete();
      done_cyc = -1; n_agg = 0; n_comb = 0; busy_cycles = 0; stab_err = 0;
      done_cnt = 3'd7; err_at_done = 1'bx;
      last_node = 2'd0; last_mask = 4'h0;
      for (int t = 0; t < max_cyc; t++) begin
         @(posedge clk); #1;
         start    = (t == 0) || (t == restart_cyc);
         eng_done = (t == pend) || (t == spur_cyc);
         adj      = (t == 0) ? a : ~a;
         node_en  = (t == 0) ? en : ~en;
         @(negedge clk);
         if (agg_load) begin
            n_agg++; node_log.push_back(cur_node); mask_log.push_back(agg_mask);
            last_node = cur_node; last_mask = agg_mask;
         end
         if (eng_start) begin
            es_cyc.push_back(t);
            if (lat > 0) pend = t + lat;
         end
         if ((eng_start || comb_load) && (cur_node !== last_node || agg_mask !== last_mask)) stab_err++;
         if (comb_load) n_comb++;
         if (busy) busy_cycles++;
         if (done && done_cyc < 0) begin
            done_cyc = t; done_cnt = node_cnt; err_at_done = err;
         end
         if (done_cyc >= 0 && t > done_cyc) break;
      end
      @(posedge clk); #1;
      start = 1'b0; eng_done = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if ({cur_node, agg_mask, node_cnt} !== 9'd0) begin errors++;
         $display("FAIL reset_vec: cur_node=%0d mask=%0h cnt=%0d, need 0", cur_node, agg_mask, node_cnt); end
      checks++; if ({agg_load, eng_start, comb_load, busy, done, err} !== 6'd0) begin errors++;
         $display("FAIL reset_flags: %b, need 000000", {agg_load, eng_start, comb_load, busy, done, err}); end
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b need 0", busy); end
   endtask

   task automatic check_full_schedule(input string tag);
      int         exp_es[4];
      logic [3:0] exp_mask[4];
      exp_es = '{2, 8, 14, 20};
      exp_mask = '{4'hE, 4'hD, 4'hB, 4'h7};
      checks++; if (es_cyc.size() != 4) begin errors++;
         $display("FAIL %s_es_count: got %0d need 4", tag, es_cyc.size()); end
      for (int i = 0; i < 4 && i < es_cyc.size(); i++) begin
         checks++; if (es_cyc[i] != exp_es[i]) begin errors++;
            $display("FAIL %s_es_cycle[%0d]: got %0d need %0d", tag, i, es_cyc[i], exp_es[i]); end
      end
      for (int i = 0; i < 4 && i < mask_log.size(); i++) begin
         checks++; if (mask_log[i] !== exp_mask[i] || node_log[i] !== 2'(i)) begin errors++;
            $display("FAIL %s_agg[%0d]: mask=%0h node=%0d need mask=%0h node=%0d",
                     tag, i, mask_log[i], node_log[i], exp_mask[i], i); end
      end
      checks++; if (done_cyc != 25) begin errors++; $display("FAIL %s_done_cycle: got %0d need 25", tag, done_cyc); end
      checks++; if (done_cnt !== 3'd4) begin errors++; $display("FAIL %s_node_cnt: got %0d need 4", tag, done_cnt); end
      checks++; if (n_comb != 4 || n_agg != 4) begin errors++;
         $display("FAIL %s_pulses: agg=%0d comb=%0d need 4/4", tag, n_agg, n_comb); end
      checks++; if (busy_cycles != 25) begin errors++; $display("FAIL %s_busy: got %0d cycles need 25", tag, busy_cycles); end
      checks++; if (stab_err != 0) begin errors++; $display("FAIL %s_stable: got %0d changes need 0", tag, stab_err); end
   endtask

   task automatic test_full_pass;
      run_pass(16'h7BDE, 4'hF, 3, 60, -1, -1);
      check_full_schedule("full");
   endtask

   task automatic test_sparse;
      run_pass(16'h1234, 4'b0101, 1, 40, -1, -1);
      checks++; if (node_log.size() != 2) begin errors++; $display("FAIL sparse_nodes: got %0d need 2", node_log.size()); end
      if (node_log.size() == 2) begin
         checks++; if (node_log[0] !== 2'd0 || node_log[1] !== 2'd2) begin errors++;
            $display("FAIL sparse_order: got %0d,%0d need 0,2", node_log[0], node_log[1]); end
         checks++; if (mask_log[0] !== 4'h4 || mask_log[1] !== 4'h2) begin errors++;
            $display("FAIL sparse_mask: got %0h,%0h need 4,2", mask_log[0], mask_log[1]); end
      end
      checks++; if (done_cyc != 9) begin errors++; $display("FAIL sparse_done_cycle: got %0d need 9", done_cyc); end
      checks++; if (done_cnt !== 3'd2) begin errors++; $display("FAIL sparse_node_cnt: got %0d need 2", done_cnt); end
   endtask

   task automatic test_single_top;
      run_pass(16'hA000, 4'b1000, 2, 40, -1, -1);
      checks++; if (es_cyc.size() != 1 || node_log.size() != 1) begin errors++;
         $display("FAIL top_count: es=%0d agg=%0d need 1/1", es_cyc.size(), node_log.size()); end
      else begin
         checks++; if (node_log[0] !== 2'd3 || mask_log[0] !== 4'hA || es_cyc[0] != 2) begin errors++;
            $display("FAIL top_node: node=%0d mask=%0h es=%0d need 3/a/2", node_log[0], mask_log[0], es_cyc[0]); end
      end
      checks++; if (done_cyc != 6 || done_cnt !== 3'd1) begin errors++;
         $display("FAIL top_done: cycle=%0d cnt=%0d need 6/1", done_cyc, done_cnt); end
   endtask

   task automatic test_empty;
      run_pass(16'hFFFF, 4'h0, 1, 20, -1, -1);
      checks++; if (done_cyc != 1) begin errors++; $display("FAIL empty_done_cycle: got %0d need 1", done_cyc); end
      checks++; if (busy_cycles != 1) begin errors++; $display("FAIL empty_busy: got %0d need 1", busy_cycles); end
      checks++; if (n_agg != 0 || es_cyc.size() != 0 || n_comb != 0) begin errors++;
         $display("FAIL empty_pulses: agg=%0d es=%0d comb=%0d need 0", n_agg, es_cyc.size(), n_comb); end
      checks++; if (done_cnt !== 3'd0) begin errors++; $display("FAIL empty_node_cnt: got %0d need 0", done_cnt); end
   endtask

   task automatic test_ignored_inputs;
      run_pass(16'h7BDE, 4'hF, 3, 60, 4, 1);
      check_full_schedule("ignore");
   endtask

   task automatic test_reset_mid_pass;
      int seen_done, seen_busy;
      @(posedge clk); #1;
      start = 1'b1; adj = 16'h7BDE; node_en = 4'hF;
      for (int t = 1; t <= 9; t++) begin
         @(posedge clk); #1;
         start = 1'b0; eng_done = (t == 5);
      end
      checks++; if (busy !== 1'b1 || cur_node !== 2'd1 || eng_start !== 1'b0) begin errors++;
         $display("FAIL abort_pre: busy=%b node=%0d es=%b need 1/1/0", busy, cur_node, eng_start); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if ({cur_node, agg_mask, node_cnt, agg_load, eng_start, comb_load, busy, done, err} !== 15'd0) begin
         errors++; $display("FAIL abort_async: node=%0d mask=%0h cnt=%0d busy=%b need all 0",
                            cur_node, agg_mask, node_cnt, busy); end
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0; seen_busy = 0;
      repeat (12) begin
         @(negedge clk);
         if (done) seen_done++;
         if (busy) seen_busy++;
      end
      checks++; if (seen_done != 0 || seen_busy != 0) begin errors++;
         $display("FAIL abort_no_done: done=%0d busy=%0d need 0/0", seen_done, seen_busy); end
      run_pass(16'h7BDE, 4'hF, 3, 60, -1, -1);
      check_full_schedule("after_abort");
   endtask

   task automatic test_timeout;
`ifdef GNN_SCHED_TIMEOUT_EN
      run_pass(16'h0003, 4'b0001, 0, 300, -1, -1);
      checks++; if (done_cyc != 260) begin errors++; $display("FAIL tout_done_cycle: got %0d need 260", done_cyc); end
      checks++; if (err_at_done !== 1'b1 || done_cnt !== 3'd0 || n_comb != 0) begin errors++;
         $display("FAIL tout_state: err=%b cnt=%0d comb=%0d need 1/0/0", err_at_done, done_cnt, n_comb); end
      @(negedge clk);
      checks++; if (err !== 1'b1) begin errors++; $display("FAIL tout_sticky: got %b need 1", err); end
      run_pass(16'h0003, 4'b0001, 1, 30, -1, -1);
      checks++; if (err_at_done !== 1'b0 || done_cyc != 5) begin errors++;
         $display("FAIL tout_clear: err=%b done=%0d need 0/5", err_at_done, done_cyc); end
`else
      run_pass(16'h0003, 4'b0001, 0, 300, -1, -1);
      checks++; if (done_cyc != -1) begin errors++; $display("FAIL hang_done: got cycle %0d need none", done_cyc); end
      checks++; if (busy_cycles != 299) begin errors++; $display("FAIL hang_busy: got %0d need 299", busy_cycles); end
      checks++; if (err !== 1'b0) begin errors++; $display("FAIL hang_err: got %b need 0", err); end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hang_recover: busy=%b need 0", busy); end
`endif
   endtask

   initial begin
      test_reset();
      test_full_pass();
      test_sparse();
      test_single_top();
      test_empty();
      test_ignored_inputs();
      test_reset_mid_pass();
      test_timeout();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
